// File: rtl/adv_timer_cmd_sched.sv
// Command scheduler for the adv_timer instances. Commands are queued with
// a timer mask, an operation and a delay. Each command waits out its delay
// and then drives a one-cycle cfg_* pulse to every selected timer, all in
// the same cycle.
module adv_timer_cmd_sched #(
  parameter int N_TIMERS = 4,
  parameter int DEPTH    = 4,
  parameter int DLY_W    = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [N_TIMERS-1:0]        cmd_mask_i,
  input  logic [2:0]                 cmd_op_i,
  input  logic [DLY_W-1:0]           cmd_delay_i,
  input  logic                       flush_i,
  output logic [N_TIMERS-1:0]        cfg_start_o,
  output logic [N_TIMERS-1:0]        cfg_stop_o,
  output logic [N_TIMERS-1:0]        cfg_rst_o,
  output logic [N_TIMERS-1:0]        cfg_update_o,
  output logic [N_TIMERS-1:0]        cfg_arm_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_STOP   = 3'd1;
  localparam logic [2:0] OP_RST    = 3'd2;
  localparam logic [2:0] OP_UPDATE = 3'd3;
  localparam logic [2:0] OP_ARM    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE
  } state_e;

  typedef struct packed {
    logic [N_TIMERS-1:0] mask;
    logic [2:0]          op;
    logic [DLY_W-1:0]    delay;
  } cmd_t;

  // Queue storage and bookkeeping
  cmd_t                fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  // Scheduler state and the command currently being timed
  state_e              state_q, state_d;
  logic [N_TIMERS-1:0] wk_mask_q, wk_mask_d;
  logic [2:0]          wk_op_q, wk_op_d;
  logic [DLY_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                full;
  logic                accept;
  logic                op_legal;
  logic                push;
  logic                pop;
  cmd_t                cmd_in;
  cmd_t                head;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign accept   = cmd_valid_i && !full;
  assign op_legal = (cmd_op_i <= OP_ARM);
  // A flush swallows a same-edge accept entirely, including its error flag.
  assign push     = accept && op_legal && !flush_i;
  assign cmd_in   = '{mask: cmd_mask_i, op: cmd_op_i, delay: cmd_delay_i};
  assign head     = fifo_mem_q[rd_ptr_q];

  // Next-state logic: scheduler FSM, pop request and working-register loads
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    wk_mask_d = wk_mask_q;
    wk_op_d   = wk_op_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    if (flush_i) begin
      // A WAIT in progress is dropped; an ISSUE cycle has already shown its pulses.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            pop       = 1'b1;
            wk_mask_d = head.mask;
            wk_op_d   = head.op;
            cnt_d     = head.delay;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_ISSUE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_ISSUE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Queue pointer and occupancy update; a flush empties the queue outright
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = accept && !op_legal && !flush_i;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  // Control and status registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      wk_mask_q <= '0;
      wk_op_q   <= OP_START;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      wk_mask_q <= wk_mask_d;
      wk_op_q   <= wk_op_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_q     <= err_d;
    end
  end

  // Queue payload storage, written on push only
  always_ff @(posedge HCLK) begin
    // NOTE: payload storage is not reset; entries are only read after being written, as tracked by level_q.
    if (push) fifo_mem_q[wr_ptr_q] <= cmd_in;
  end

  // Pulse decode: only the vector matching the working op carries the mask
  always_comb begin
    cfg_start_o  = '0;
    cfg_stop_o   = '0;
    cfg_rst_o    = '0;
    cfg_update_o = '0;
    cfg_arm_o    = '0;
    if (state_q == S_ISSUE) begin
      unique case (wk_op_q)
        OP_START:  cfg_start_o  = wk_mask_q;
        OP_STOP:   cfg_stop_o   = wk_mask_q;
        OP_RST:    cfg_rst_o    = wk_mask_q;
        OP_UPDATE: cfg_update_o = wk_mask_q;
        OP_ARM:    cfg_arm_o    = wk_mask_q;
        default:   ;
      endcase
    end
  end

  assign cmd_ready_o = !full;
  assign level_o     = level_q;
  assign busy_o      = (state_q != S_IDLE) || (level_q != '0);
  assign done_o      = (state_q == S_ISSUE);
  assign err_o       = err_q;

endmodule
